// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
package rv_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {SRC_ALU, SRC_LSU} wb_src_e;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU side, bit 1 the LSU side.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    import rv_wb_pkg::*;

    wb_src_e last_grant;

    // On a tie the requester that did not win most recently is served.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == SRC_ALU) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= SRC_ALU;
        end else if (|grant) begin
            last_grant <= grant[1] ? SRC_LSU : SRC_ALU;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter (ALU vs load return) with an in-flight load scoreboard.
module reg_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            lsu_wb_valid,
    input  logic [4:0]      lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_ready,
    input  logic            iss_valid,
    input  logic            iss_load,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    output logic            iss_stall,
    output logic            rf_reg_write,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic [NREG-1:0] busy
);
    import rv_wb_pkg::*;

    logic [1:0]            grant;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;
    logic [NREG-1:0]       busy_next;
    logic                  load_issue;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({lsu_wb_valid, alu_wb_valid}),
        .grant (grant)
    );

    assign alu_wb_ready = grant[0];
    assign lsu_wb_ready = grant[1];

    always_comb begin
        win_rd   = alu_wb_rd;
        win_data = alu_wb_data;
        if (grant[1]) begin
            win_rd   = lsu_wb_rd;
            win_data = lsu_wb_data;
        end
    end

    // x0 writes are still accepted upstream but never reach the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_reg_write  <= 1'b0;
            rf_rd_addr    <= '0;
            rf_write_data <= '0;
        end else if (|grant) begin
            rf_reg_write  <= (win_rd != '0);
            rf_rd_addr    <= win_rd;
            rf_write_data <= win_data;
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

    assign iss_stall  = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
    assign load_issue = iss_valid & iss_load & ~iss_stall & (iss_rd != '0);

    // Set is applied after clear so a new load to the returning register stays tracked.
    always_comb begin
        busy_next = busy;
        if (grant[1]) begin
            busy_next[lsu_wb_rd] = 1'b0;
        end
        if (load_issue) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench: the driver predicts grants, stalls and register writes; a negedge monitor checks writes.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_ready;
    logic        iss_valid;
    logic        iss_load;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_stall;
    logic        rf_reg_write;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_write_data;
    logic [31:0] busy;

    reg_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_rd     (alu_wb_rd),
        .alu_wb_data   (alu_wb_data),
        .alu_wb_ready  (alu_wb_ready),
        .lsu_wb_valid  (lsu_wb_valid),
        .lsu_wb_rd     (lsu_wb_rd),
        .lsu_wb_data   (lsu_wb_data),
        .lsu_wb_ready  (lsu_wb_ready),
        .iss_valid     (iss_valid),
        .iss_load      (iss_load),
        .iss_rs1       (iss_rs1),
        .iss_rs2       (iss_rs2),
        .iss_rd        (iss_rd),
        .iss_stall     (iss_stall),
        .rf_reg_write  (rf_reg_write),
        .rf_rd_addr    (rf_rd_addr),
        .rf_write_data (rf_write_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   started = 0;

    // Reference state: which registers have a load outstanding, and who won the last grant.
    bit   in_flight[32];
    bit   last_was_lsu;
    bit   last_ga, last_gl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        foreach (in_flight[i]) in_flight[i] = 0;
        last_was_lsu = 0;
        exp_q.delete();
    endtask

    function automatic bit hazard(input logic [4:0] r);
        return (r != 0) && in_flight[r];
    endfunction

    // Called at posedge+1 with inputs settled; returns at the next posedge+1.
    task automatic cycle();
        bit ga, gl, st;
        logic [31:0] exp_busy;
        #1;
        if (alu_wb_valid && lsu_wb_valid) begin
            gl = !last_was_lsu;
            ga = !gl;
        end else begin
            ga = alu_wb_valid;
            gl = lsu_wb_valid;
        end
        st = iss_valid && (hazard(iss_rs1) || hazard(iss_rs2) || hazard(iss_rd));
        for (int i = 0; i < 32; i++) exp_busy[i] = in_flight[i];
        check("alu_ready", alu_wb_ready, ga);
        check("lsu_ready", lsu_wb_ready, gl);
        check("stall", iss_stall, st);
        check("busy", busy, exp_busy);
        if (ga || gl) last_was_lsu = gl;
        if (ga && alu_wb_rd != 0) exp_q.push_back('{cyc + 1, alu_wb_rd, alu_wb_data});
        if (gl && lsu_wb_rd != 0) exp_q.push_back('{cyc + 1, lsu_wb_rd, lsu_wb_data});
        if (gl) in_flight[lsu_wb_rd] = 0;
        if (iss_valid && iss_load && !st && iss_rd != 0) in_flight[iss_rd] = 1;
        last_ga = ga;
        last_gl = gl;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rf_write", {rf_reg_write, rf_rd_addr, rf_write_data}, {1'b1, e.rd, e.data});
            end else begin
                check("rf_idle", rf_reg_write, 1'b0);
            end
        end
    end

    task automatic idle_inputs();
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
        iss_valid = 0; iss_load = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        check("reset_busy", busy, 32'h0);
        check("reset_rf_we", rf_reg_write, 1'b0);
        check("reset_rf_addr", rf_rd_addr, 5'd0);
        started = 1;

        // Single ALU write
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'h0000_00AA;
        cycle();
        alu_wb_valid = 0;
        check("alu_first_addr", rf_rd_addr, 5'd5);
        check("alu_first_data", rf_write_data, 32'hAA);
        cycle();

        // Sustained tie: LSU, ALU, LSU, ALU
        alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 32'h11;
        lsu_wb_valid = 1; lsu_wb_rd = 2; lsu_wb_data = 32'h22;
        repeat (4) cycle();
        idle_inputs();
        cycle();

        // Load to x7 then dependent ADD stalls until the return is accepted
        iss_valid = 1; iss_load = 1; iss_rd = 7;
        cycle();
        iss_load = 0; iss_rs1 = 7; iss_rs2 = 3; iss_rd = 8;
        repeat (3) cycle();
        lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 32'hDEAD_BEEF;
        cycle();
        lsu_wb_valid = 0;
        check("busy7_cleared", busy[7], 1'b0);
        cycle();
        idle_inputs();

        // Load to x9 and then a new load to x9 issued on the edge the first returns
        iss_valid = 1; iss_load = 1; iss_rd = 9;
        cycle();
        iss_valid = 0;
        cycle();
        iss_valid = 1; iss_load = 1; iss_rd = 9; iss_rs1 = 0; iss_rs2 = 0;
        lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'h99;
        // Issue would stall on the pending x9, so this return clears it first
        cycle();
        idle_inputs();
        cycle();
        check("busy9_after_clear", busy[9], 1'b0);
        iss_valid = 1; iss_load = 1; iss_rd = 9;
        cycle();
        iss_valid = 1; iss_load = 0; iss_rd = 0;
        lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'h98;
        cycle();
        idle_inputs();
        iss_valid = 1; iss_load = 1; iss_rd = 12;
        lsu_wb_valid = 1; lsu_wb_rd = 12; lsu_wb_data = 32'h12;
        cycle();
        idle_inputs();
        check("busy12_set_wins", busy[12], 1'b1);
        lsu_wb_valid = 1; lsu_wb_rd = 12; lsu_wb_data = 32'h13;
        cycle();
        idle_inputs();

        // x0 destinations and operands
        alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h5555;
        cycle();
        idle_inputs();
        iss_valid = 1; iss_load = 1; iss_rd = 0;
        cycle();
        idle_inputs();
        check("busy0_never", busy[0], 1'b0);
        iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        cycle();
        idle_inputs();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            if (!alu_wb_valid || last_ga) begin
                alu_wb_valid = ($urandom_range(0, 99) < 55);
                alu_wb_rd    = 5'($urandom_range(0, 31));
                alu_wb_data  = $urandom;
            end
            if (!lsu_wb_valid || last_gl) begin
                lsu_wb_valid = ($urandom_range(0, 99) < 45);
                lsu_wb_rd    = 5'($urandom_range(0, 15));
                lsu_wb_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 99) < 70);
            iss_load  = ($urandom_range(0, 99) < 40);
            iss_rs1   = 5'($urandom_range(0, 15));
            iss_rs2   = 5'($urandom_range(0, 15));
            iss_rd    = 5'($urandom_range(0, 15));
            cycle();
        end
        idle_inputs();
        repeat (20) begin
            for (int r = 1; r < 32; r++) begin
                if (in_flight[r] && !lsu_wb_valid) begin
                    lsu_wb_valid = 1; lsu_wb_rd = 5'(r); lsu_wb_data = $urandom;
                end
            end
            cycle();
            if (last_gl) lsu_wb_valid = 0;
        end
        idle_inputs();
        cycle();

        // Asynchronous reset with both sources pending and x3 in flight
        iss_valid = 1; iss_load = 1; iss_rd = 3;
        alu_wb_valid = 1; alu_wb_rd = 4; alu_wb_data = 32'h44;
        cycle();
        iss_valid = 0;
        alu_wb_rd = 6; alu_wb_data = 32'h66;
        lsu_wb_valid = 1; lsu_wb_rd = 10; lsu_wb_data = 32'hA0;
        check("busy3_before_reset", busy[3], 1'b1);
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        check("async_reset_busy", busy, 32'h0);
        check("async_reset_rf_we", rf_reg_write, 1'b0);
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        reset = 0;
        cycle();
        check("post_reset_lsu_first", last_gl, 1'b1);
        lsu_wb_valid = 0;
        cycle();
        idle_inputs();
        repeat (2) cycle();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
